// File: rtl/debit_pin_pkg.sv
// debit_pin_pkg: shared state encoding and default parameter constants for the
// debit PIN entry block. The LOCKED state exists only when DEBIT_PIN_LOCKOUT_EN
// is defined.
package debit_pin_pkg;

    localparam int          DEF_NUM_DIGITS     = 4;
    localparam int          DEF_DIGIT_W        = 2;
    localparam logic [7:0]  DEF_PASSKEY        = 8'b10_01_11_00;
    localparam int          DEF_MAX_TRIES      = 3;
    localparam int          DEF_LOCKOUT_CYCLES = 16;
    localparam int          DEF_RESULT_HOLD    = 8;

`ifdef DEBIT_PIN_LOCKOUT_EN
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ENTRY     = 3'd1,
        ST_CORRECT   = 3'd2,
        ST_INCORRECT = 3'd3,
        ST_LOCKED    = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ENTRY     = 3'd1,
        ST_CORRECT   = 3'd2,
        ST_INCORRECT = 3'd3
    } state_t;
`endif

endpackage

// File: rtl/debit_pin_multi_digit_encoder.sv
// digit_encoder: highest-set-bit encoder turning the one-switch-per-value bus
// into a binary digit. valid is low when no switch is set.
module digit_encoder #(
    parameter int DIGIT_W = 2
) (
    input  logic [2**DIGIT_W-1:0] i_switches,
    output logic [DIGIT_W-1:0]    o_digit,
    output logic                  o_valid
);

    // Scan upward so the highest set switch overrides any lower ones.
    always_comb begin
        o_digit = '0;
        o_valid = 1'b0;
        for (int i = 0; i < 2**DIGIT_W; i++) begin
            if (i_switches[i]) begin
                o_digit = DIGIT_W'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/debit_pin_multi.sv
// debit_pin_multi: multi-digit PIN entry with edge-triggered digit capture,
// timed correct/incorrect indication and (with DEBIT_PIN_LOCKOUT_EN defined)
// a timed lockout after MAX_TRIES consecutive failures.
module debit_pin_multi
    import debit_pin_pkg::*;
#(
    parameter int                              NUM_DIGITS     = DEF_NUM_DIGITS,
    parameter int                              DIGIT_W        = DEF_DIGIT_W,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0]   PASSKEY        = DEF_PASSKEY,
    parameter int                              MAX_TRIES      = DEF_MAX_TRIES,
    parameter int                              LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int                              RESULT_HOLD    = DEF_RESULT_HOLD
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [2**DIGIT_W-1:0]             digit_switches,
    input  logic                              submit,
    output logic                              waiting,
    output logic                              correct,
    output logic                              incorrect,
    output logic                              locked,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count
);

    localparam int CNT_W   = $clog2(NUM_DIGITS + 1);
    localparam int PIN_W   = NUM_DIGITS * DIGIT_W;
    // One timer serves both hold phases; sized for the longest of them.
    localparam int TMR_MAX = (RESULT_HOLD > LOCKOUT_CYCLES)
                           ? ((RESULT_HOLD > MAX_TRIES) ? RESULT_HOLD : MAX_TRIES)
                           : ((LOCKOUT_CYCLES > MAX_TRIES) ? LOCKOUT_CYCLES : MAX_TRIES);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_submit_q;
    logic [CNT_W-1:0]   r_digit_count;
    logic [CNT_W-1:0]   w_count_next;
    logic [PIN_W-1:0]   r_digits;
    logic [PIN_W-1:0]   w_digits_next;
    logic [PIN_W-1:0]   w_entry;
    logic [TMR_W-1:0]   r_timer;
    logic [TMR_W-1:0]   w_timer_next;
    logic [DIGIT_W-1:0] w_digit;
    logic               w_valid;
    logic               w_edge;
    logic               r_waiting;
    logic               r_correct;
    logic               r_incorrect;
    logic               r_locked;
`ifdef DEBIT_PIN_LOCKOUT_EN
    localparam int FAIL_W = $clog2(MAX_TRIES + 1);
    logic [FAIL_W-1:0]  r_fail_count;
    logic [FAIL_W-1:0]  w_fail_next;
`endif

    digit_encoder #(.DIGIT_W(DIGIT_W)) u_enc (
        .i_switches (digit_switches),
        .o_digit    (w_digit),
        .o_valid    (w_valid)
    );

    assign w_edge = submit & ~r_submit_q;

    // Candidate entry: stored digits with the new digit dropped into the
    // current slot; first digit lives in the most significant slice.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
            localparam int LSB = (NUM_DIGITS - 1 - gi) * DIGIT_W;
            assign w_entry[LSB +: DIGIT_W] = (r_digit_count == CNT_W'(gi))
                                           ? w_digit : r_digits[LSB +: DIGIT_W];
        end
    endgenerate

    // Next-state, counter, timer and failure bookkeeping.
    always_comb begin
        w_state_next  = r_state;
        w_count_next  = r_digit_count;
        w_digits_next = r_digits;
        w_timer_next  = r_timer + TMR_W'(1);
`ifdef DEBIT_PIN_LOCKOUT_EN
        w_fail_next   = r_fail_count;
`endif
        case (r_state)
            ST_IDLE, ST_ENTRY: begin
                w_timer_next = '0;
                if (w_edge && w_valid) begin
                    if (r_digit_count == CNT_W'(NUM_DIGITS - 1)) begin
                        w_count_next  = '0;
                        w_digits_next = '0;
                        if (w_entry == PASSKEY) begin
                            w_state_next = ST_CORRECT;
`ifdef DEBIT_PIN_LOCKOUT_EN
                            w_fail_next  = '0;
`endif
                        end else begin
                            w_state_next = ST_INCORRECT;
`ifdef DEBIT_PIN_LOCKOUT_EN
                            if (r_fail_count != FAIL_W'(MAX_TRIES))
                                w_fail_next = r_fail_count + FAIL_W'(1);
`endif
                        end
                    end else begin
                        w_count_next  = r_digit_count + CNT_W'(1);
                        w_digits_next = w_entry;
                        w_state_next  = ST_ENTRY;
                    end
                end
            end
            ST_CORRECT: begin
                if (r_timer == TMR_W'(RESULT_HOLD - 1)) begin
                    w_state_next = ST_IDLE;
                    w_timer_next = '0;
                end
            end
            ST_INCORRECT: begin
                if (r_timer == TMR_W'(RESULT_HOLD - 1)) begin
                    w_timer_next = '0;
                    w_state_next = ST_IDLE;
`ifdef DEBIT_PIN_LOCKOUT_EN
                    if (r_fail_count == FAIL_W'(MAX_TRIES))
                        w_state_next = ST_LOCKED;
`endif
                end
            end
`ifdef DEBIT_PIN_LOCKOUT_EN
            ST_LOCKED: begin
                if (r_timer == TMR_W'(LOCKOUT_CYCLES - 1)) begin
                    w_state_next = ST_IDLE;
                    w_timer_next = '0;
                    w_fail_next  = '0;
                end
            end
`endif
            default: begin
                w_state_next = ST_IDLE;
                w_count_next = '0;
                w_timer_next = '0;
            end
        endcase
    end

    // State register plus outputs decoded from the next state, so every
    // output is a flop aligned with the state it reflects.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_submit_q    <= 1'b1;
            r_digit_count <= '0;
            r_digits      <= '0;
            r_timer       <= '0;
            r_waiting     <= 1'b1;
            r_correct     <= 1'b0;
            r_incorrect   <= 1'b0;
            r_locked      <= 1'b0;
`ifdef DEBIT_PIN_LOCKOUT_EN
            r_fail_count  <= '0;
`endif
        end else begin
            r_state       <= w_state_next;
            r_submit_q    <= submit;
            r_digit_count <= w_count_next;
            r_digits      <= w_digits_next;
            r_timer       <= w_timer_next;
            r_waiting     <= (w_state_next == ST_IDLE) || (w_state_next == ST_ENTRY);
            r_correct     <= (w_state_next == ST_CORRECT);
            r_incorrect   <= (w_state_next == ST_INCORRECT);
`ifdef DEBIT_PIN_LOCKOUT_EN
            r_locked      <= (w_state_next == ST_LOCKED);
            r_fail_count  <= w_fail_next;
`else
            r_locked      <= 1'b0;
`endif
        end
    end

    assign waiting     = r_waiting;
    assign correct     = r_correct;
    assign incorrect   = r_incorrect;
    assign locked      = r_locked;
    assign digit_count = r_digit_count;

endmodule

// File: tb/tb_debit_pin_multi.sv
// tb_debit_pin_multi: directed-vector bench for debit_pin_multi with default
// parameters (PASSKEY digits 2,1,3,0). Lockout checks follow
// DEBIT_PIN_LOCKOUT_EN.
module tb_debit_pin_multi;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] digit_switches = 4'b0000;
    logic       submit = 1'b0;
    logic       waiting, correct, incorrect, locked;
    logic [2:0] digit_count;

    int n_checks = 0;
    int n_pass   = 0;
    logic saw_locked = 1'b0;

    debit_pin_multi dut (
        .clk            (clk),
        .reset          (reset),
        .digit_switches (digit_switches),
        .submit         (submit),
        .waiting        (waiting),
        .correct        (correct),
        .incorrect      (incorrect),
        .locked         (locked),
        .digit_count    (digit_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (!reset && locked) saw_locked <= 1'b1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
            $display("check %-16s got %0d exp %0d ok", tag, got, exp);
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One submit pulse; returns on the negedge after the capturing posedge.
    task automatic press(input logic [3:0] sw);
        @(negedge clk);
        digit_switches = sw;
        submit = 1'b1;
        @(negedge clk);
        submit = 1'b0;
    endtask

    task automatic enter_pin(input logic [7:0] pin);
        logic [1:0] d;
        for (int i = 0; i < 4; i++) begin
            d = pin[(3-i)*2 +: 2];
            press(4'b0001 << d);
        end
    endtask

    // Counts consecutive cycles the selected output stays high (0 correct,
    // 1 incorrect, 2 locked); also pulses submit while doing so.
    task automatic count_high(input int which, input bit poke, output int n);
        logic v;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            v = (which == 0) ? correct : (which == 1) ? incorrect : locked;
            if (!v) break;
            n++;
            if (poke) begin
                digit_switches = 4'b0100;
                submit = ~submit;
            end
            @(negedge clk);
        end
        submit = 1'b0;
    endtask

    task automatic wait_waiting();
        int n = 0;
        while (!waiting && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_timeout", int'(waiting), 1);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_waiting", waiting, 1);
        check("rst_correct", correct, 0);
        check("rst_incorrect", incorrect, 0);
        check("rst_locked", locked, 0);
        check("rst_count", digit_count, 0);

        // Correct PIN 2,1,3,0
        press(4'b0100); check("ok_cnt1", digit_count, 1);
        press(4'b0010); check("ok_cnt2", digit_count, 2);
        press(4'b1000); check("ok_cnt3", digit_count, 3);
        press(4'b0001);
        check("ok_correct", correct, 1);
        check("ok_cnt0", digit_count, 0);
        count_high(0, 1'b1, n);
        check("ok_hold", n, 8);
        check("ok_waiting", waiting, 1);
        check("ok_discard", digit_count, 0);

        // Wrong PIN 2,1,3,1: no early indication
        press(4'b0100); check("bad_cnt1", digit_count, 1);
        press(4'b0010); check("bad_cnt2", digit_count, 2);
        press(4'b1000); check("bad_cnt3", digit_count, 3);
        check("bad_no_early", int'(incorrect | correct), 0);
        press(4'b0010);
        check("bad_incorrect", incorrect, 1);
        check("bad_cnt0", digit_count, 0);
        count_high(1, 1'b0, n);
        check("bad_hold", n, 8);
        wait_waiting();

        // Highest bit wins; empty switches ignored
        press(4'b0110); check("enc_cnt1", digit_count, 1);
        press(4'b0000); check("empty_cnt", digit_count, 1);
        press(4'b0011);
        press(4'b1100); check("enc_cnt3", digit_count, 3);
        press(4'b0001);
        check("enc_correct", correct, 1);
        wait_waiting();

        // Submit held high through reset release
        @(negedge clk);
        reset = 1'b1; submit = 1'b1; digit_switches = 4'b0100;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rsthi_cnt", digit_count, 0);
        submit = 1'b0;

        // Reset after two digits discards progress
        press(4'b0100);
        press(4'b0010);
        check("mid_cnt2", digit_count, 2);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        check("mid_rst_cnt", digit_count, 0);
        check("mid_rst_wait", waiting, 1);
        enter_pin(8'b10_01_11_00);
        check("mid_rst_pass", correct, 1);
        wait_waiting();

`ifdef DEBIT_PIN_LOCKOUT_EN
        for (int t = 0; t < 3; t++) begin
            enter_pin(8'b00_00_00_00);
            check("lk_incorrect", incorrect, 1);
            count_high(1, 1'b0, n);
            check("lk_inc_hold", n, 8);
        end
        check("lk_locked", locked, 1);
        count_high(2, 1'b1, n);
        check("lk_hold", n, 16);
        check("lk_waiting", waiting, 1);
        check("lk_cnt", digit_count, 0);
        enter_pin(8'b10_01_11_00);
        check("lk_pass", correct, 1);
        wait_waiting();
`else
        for (int t = 0; t < 5; t++) begin
            enter_pin(8'b11_11_11_11);
            check("nl_incorrect", incorrect, 1);
            count_high(1, 1'b0, n);
            check("nl_hold", n, 8);
            check("nl_waiting", waiting, 1);
        end
        check("nl_never_locked", int'(saw_locked), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/debit_pin_multi.md
DEBIT_PIN_MULTI -- requirements
Module: debit_pin_multi

Interface
REQ-001 Parameter NUM_DIGITS, default 4: digits per PIN (min 1).
REQ-002 Parameter DIGIT_W, default 2: bits per digit; switch bus is 2**DIGIT_W wide.
REQ-003 Parameter PASSKEY, default 8'b10_01_11_00: NUM_DIGITS*DIGIT_W bits; first-entered digit in the MSB slice.
REQ-004 Parameter MAX_TRIES, default 3: consecutive failures that trigger lockout (min 1).
REQ-005 Parameter LOCKOUT_CYCLES, default 16: lockout duration in clk cycles.
REQ-006 Parameter RESULT_HOLD, default 8: cycles correct/incorrect stay asserted.
REQ-007 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-008 Port reset, input, 1: synchronous, active-high reset.
REQ-009 Port digit_switches, input, 2**DIGIT_W: one switch per digit value; highest set bit wins.
REQ-010 Port submit, input, 1: level input; each rising edge enters one digit.
REQ-011 Port waiting, output, 1: block accepting digits.
REQ-012 Port correct, output, 1: PIN matched.
REQ-013 Port incorrect, output, 1: PIN mismatched.
REQ-014 Port locked, output, 1: lockout active.
REQ-015 Port digit_count, output, $clog2(NUM_DIGITS+1): digits entered so far.

Function
REQ-016 FSM states IDLE, ENTRY, CORRECT, INCORRECT, LOCKED; all outputs registered.
REQ-017 Submit edge = submit & ~submit_q, with submit_q registered every cycle.
REQ-018 Edge with no switch set is ignored: no state or count change.
REQ-019 Valid edge in IDLE/ENTRY stores the encoded digit at slot digit_count and increments digit_count; IDLE->ENTRY on the first digit.
REQ-020 Edge completing NUM_DIGITS digits compares the full entry, including the new digit, to PASSKEY; next cycle is CORRECT or INCORRECT.
REQ-021 No comparison or indication before the last digit; a partial mismatch is not revealed.
REQ-022 waiting=1 only in IDLE/ENTRY; correct=1 only in CORRECT; incorrect=1 only in INCORRECT; locked=1 only in LOCKED.
REQ-023 CORRECT: clears fail_count; held RESULT_HOLD cycles, then IDLE.
REQ-024 INCORRECT: fail_count increments on entry; held RESULT_HOLD cycles, then IDLE, or LOCKED if fail_count==MAX_TRIES.
REQ-025 LOCKED: held LOCKOUT_CYCLES cycles, then IDLE with fail_count=0.
REQ-026 digit_count returns to 0 on entry to CORRECT/INCORRECT and stays 0 until the next accepted digit.
REQ-027 Submit edges in CORRECT, INCORRECT or LOCKED are discarded, including an edge on the final hold cycle.
REQ-028 fail_count saturates at MAX_TRIES and never wraps.

Reset
REQ-029 Reset: state=IDLE, waiting=1, correct=incorrect=locked=0, digit_count=0, fail_count=0, stored digits=0.
REQ-030 Reset also sets submit_q=1, so submit held high through reset enters no digit.
REQ-031 Reset mid-entry, mid-result or mid-lockout discards all progress, with no output glitch after release.

Configuration
REQ-032 Macro DEBIT_PIN_LOCKOUT_EN defined: LOCKED state, fail_count and LOCKOUT_CYCLES are active as in REQ-024/025.
REQ-033 Macro undefined: no LOCKED state and no fail_count; INCORRECT always returns to IDLE; locked tied 0.

Structure
REQ-034 Package debit_pin_pkg holds the state enum typedef and default parameter constants.
REQ-035 Sub-module digit_encoder holds the highest-set-bit encoder: in 2**DIGIT_W, out DIGIT_W, valid.

Verification
REQ-036 Switches 0100,0010,1000,0001 with one submit pulse each -> correct=1 exactly 1 cycle after the 4th edge, for 8 cycles, then waiting=1.
REQ-037 Entry 2,1,3,1 -> incorrect=1 for 8 cycles; digit_count reads 1,2,3 then 0.
REQ-038 Three wrong PINs in a row -> locked=1 for 16 cycles; submits during lockout ignored; then waiting=1 and a correct PIN passes.
REQ-039 Switches 1100 on submit -> digit 3 stored; switches 0000 on submit -> digit_count unchanged.
REQ-040 Submit held high through reset release -> digit_count stays 0; reset after 2 digits -> digit_count=0, waiting=1.
REQ-041 Build without DEBIT_PIN_LOCKOUT_EN, 5 wrong PINs -> locked never 1 and each attempt gives incorrect.
